// File: rtl/mem_stage_pkg.sv
// Shared core defines: ALU op codes, memory op codes and MEM stage FSM states.
// Helper functions decode access size, alignment and store byte enables.
package mem_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LD   = 4'd4,
    MEM_LBU  = 4'd5,
    MEM_LHU  = 4'd6,
    MEM_LWU  = 4'd7,
    MEM_SB   = 4'd8,
    MEM_SH   = 4'd9,
    MEM_SW   = 4'd10,
    MEM_SD   = 4'd11
  } mem_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } mem_state_t;

  // Stores occupy the upper half of the encoding space.
  function automatic logic is_store(mem_op_t op);
    return op[3];
  endfunction

  function automatic logic misaligned(mem_op_t op, logic [2:0] off);
    logic bad;
    bad = 1'b0;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: bad = off[0];
      MEM_LW, MEM_LWU, MEM_SW: bad = (off[1:0] != 2'b00);
      MEM_LD, MEM_SD:          bad = (off != 3'b000);
      default:                 bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [7:0] store_mask(mem_op_t op, logic [2:0] off);
    logic [7:0] m;
    m = 8'h00;
    case (op)
      MEM_SB:  m = 8'h01 << off;
      MEM_SH:  m = 8'h03 << off;
      MEM_SW:  m = 8'h0F << off;
      MEM_SD:  m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load alignment: shifts the addressed bytes down to bit 0 and
// sign- or zero-extends them to the full datapath width.
module load_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  logic [3:0]      mem_op,
  output logic [XLEN-1:0] aligned
);

  logic [XLEN-1:0] sh;

  assign sh = rdata >> {offset, 3'b000};

  always_comb begin
    aligned = sh;
    case (mem_op_t'(mem_op))
      MEM_LB:  aligned = {{(XLEN-8){sh[7]}}, sh[7:0]};
      MEM_LH:  aligned = {{(XLEN-16){sh[15]}}, sh[15:0]};
      MEM_LW:  aligned = {{(XLEN-32){sh[31]}}, sh[31:0]};
      MEM_LBU: aligned = {{(XLEN-8){1'b0}}, sh[7:0]};
      MEM_LHU: aligned = {{(XLEN-16){1'b0}}, sh[15:0]};
      MEM_LWU: aligned = {{(XLEN-32){1'b0}}, sh[31:0]};
      default: aligned = sh;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-memory access per accepted op and
// returns a registered one-cycle writeback pulse.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   store_data,
  input  logic [3:0]        mem_op,
  input  logic [4:0]        rd_addr,
  input  logic              rd_wen,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_wen,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [7:0]        dmem_wmask,
  input  logic              dmem_resp_valid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd_addr,
  output logic              wb_wen,
  output logic [XLEN-1:0]   wb_data,
  output logic              misalign
);

  mem_state_t        state;
  mem_state_t        state_nxt;
  mem_op_t           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   sdata_q;
  logic [4:0]        rd_q;
  logic              wen_q;

  mem_op_t           op_in;
  logic              accept;
  logic              bad_in;
  logic [2:0]        off_q;
  logic [XLEN-1:0]   load_val;

  assign op_in    = mem_op_t'(mem_op);
  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign bad_in   = misaligned(op_in, alu_result[2:0]);
  assign off_q    = addr_q[2:0];

  // Request side is driven purely from state and latched operands.
  assign dmem_req_valid = (state == ST_REQ);
  assign dmem_addr      = {addr_q[ADDR_W-1:3], 3'b000};
  assign dmem_wen       = is_store(op_q);
  assign dmem_wdata     = sdata_q << {off_q, 3'b000};
  assign dmem_wmask     = store_mask(op_q, off_q);

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .rdata  (dmem_rdata),
    .offset (off_q),
    .mem_op (op_q),
    .aligned(load_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (accept && op_in != MEM_NONE && !bad_in)
          state_nxt = ST_REQ;
      ST_REQ:
        if (dmem_req_ready) state_nxt = ST_WAIT;
      ST_WAIT:
        if (dmem_resp_valid) state_nxt = ST_RESP;
      ST_RESP:
        state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= MEM_NONE;
      addr_q     <= '0;
      sdata_q    <= '0;
      rd_q       <= '0;
      wen_q      <= 1'b0;
      wb_valid   <= 1'b0;
      wb_rd_addr <= '0;
      wb_wen     <= 1'b0;
      wb_data    <= '0;
      misalign   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      if (accept) begin
        op_q    <= op_in;
        addr_q  <= alu_result[ADDR_W-1:0];
        sdata_q <= store_data;
        rd_q    <= rd_addr;
        wen_q   <= rd_wen;
        if (op_in == MEM_NONE) begin
          wb_valid   <= 1'b1;
          wb_data    <= alu_result;
          wb_rd_addr <= rd_addr;
          wb_wen     <= rd_wen;
        end else if (bad_in) begin
          wb_valid   <= 1'b1;
          misalign   <= 1'b1;
          wb_data    <= alu_result;
          wb_rd_addr <= rd_addr;
          wb_wen     <= 1'b0;
        end
      end
      // Pulse is launched on the WAIT->RESP edge so it is high during RESP.
      if (state == ST_WAIT && dmem_resp_valid) begin
        wb_valid   <= 1'b1;
        wb_data    <= load_val;
        wb_rd_addr <= rd_q;
        wb_wen     <= !is_store(op_q) && wen_q && (rd_q != 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, stores, loads, misalignment,
// response stall and mid-transaction reset.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] alu_result;
  logic [63:0] store_data;
  logic [3:0]  mem_op;
  logic [4:0]  rd_addr;
  logic        rd_wen;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic        dmem_wen;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wmask;
  logic        dmem_resp_valid;
  logic [63:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic        wb_wen;
  logic [63:0] wb_data;
  logic        misalign;

  int checks = 0;
  int failures = 0;

  mem_stage #(.XLEN(64), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_result     (alu_result),
    .store_data     (store_data),
    .mem_op         (mem_op),
    .rd_addr        (rd_addr),
    .rd_wen         (rd_wen),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_addr      (dmem_addr),
    .dmem_wen       (dmem_wen),
    .dmem_wdata     (dmem_wdata),
    .dmem_wmask     (dmem_wmask),
    .dmem_resp_valid(dmem_resp_valid),
    .dmem_rdata     (dmem_rdata),
    .wb_valid       (wb_valid),
    .wb_rd_addr     (wb_rd_addr),
    .wb_wen         (wb_wen),
    .wb_data        (wb_data),
    .misalign       (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] sd, input logic [4:0] rd,
                       input logic we);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    in_valid   = 1'b1;
    mem_op     = op;
    alu_result = a;
    store_data = sd;
    rd_addr    = rd;
    rd_wen     = we;
    @(negedge clk);
    in_valid = 1'b0;
    mem_op   = 4'd0;
  endtask

  task automatic finish_txn(input logic [63:0] rdata);
    int n;
    n = 0;
    while (!dmem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!dmem_req_valid) chk("req_timeout", 64'(dmem_req_valid), 64'd1);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_rdata      = rdata;
    @(negedge clk);
    dmem_resp_valid = 1'b0;
  endtask

  logic [3:0]  lt_op   [7];
  logic [63:0] lt_addr [7];
  logic [63:0] lt_rdata[7];
  logic [63:0] lt_exp  [7];

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    alu_result = '0;
    store_data = '0;
    mem_op = 4'd0;
    rd_addr = '0;
    rd_wen = 1'b0;
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_rdata = '0;

    lt_op[0] = MEM_LB;  lt_addr[0] = 64'h2003;
    lt_rdata[0] = 64'h00000000_80000000; lt_exp[0] = 64'hFFFFFFFF_FFFFFF80;
    lt_op[1] = MEM_LBU; lt_addr[1] = 64'h2003;
    lt_rdata[1] = 64'h00000000_80000000; lt_exp[1] = 64'h00000000_00000080;
    lt_op[2] = MEM_LW;  lt_addr[2] = 64'h4000;
    lt_rdata[2] = 64'h12345678_87654321; lt_exp[2] = 64'hFFFFFFFF_87654321;
    lt_op[3] = MEM_LWU; lt_addr[3] = 64'h4004;
    lt_rdata[3] = 64'h12345678_87654321; lt_exp[3] = 64'h00000000_12345678;
    lt_op[4] = MEM_LHU; lt_addr[4] = 64'h4006;
    lt_rdata[4] = 64'h12345678_87654321; lt_exp[4] = 64'h00000000_00001234;
    lt_op[5] = MEM_LH;  lt_addr[5] = 64'h4002;
    lt_rdata[5] = 64'h00000000_80010000; lt_exp[5] = 64'hFFFFFFFF_FFFF8001;
    lt_op[6] = MEM_LD;  lt_addr[6] = 64'h4008;
    lt_rdata[6] = 64'hFEDCBA98_76543210; lt_exp[6] = 64'hFEDCBA98_76543210;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_req_valid", 64'(dmem_req_valid), 64'd0);
    chk("rst_dmem_addr", 64'(dmem_addr), 64'd0);
    chk("rst_wmask", 64'(dmem_wmask), 64'd0);
    chk("rst_wdata", dmem_wdata, 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_misalign", 64'(misalign), 64'd0);

    issue(MEM_NONE, 64'h1234, 64'd0, 5'd3, 1'b1);
    chk("none_wb_valid", 64'(wb_valid), 64'd1);
    chk("none_wb_data", wb_data, 64'h1234);
    chk("none_wb_wen", 64'(wb_wen), 64'd1);
    chk("none_wb_rd", 64'(wb_rd_addr), 64'd3);
    chk("none_req", 64'(dmem_req_valid), 64'd0);
    @(negedge clk);
    chk("none_pulse_end", 64'(wb_valid), 64'd0);
    chk("none_req2", 64'(dmem_req_valid), 64'd0);

    issue(MEM_SW, 64'h1004, 64'hDEADBEEF, 5'd7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("sw_req_valid", 64'(dmem_req_valid), 64'd1);
      chk("sw_addr", 64'(dmem_addr), 64'h1000);
      chk("sw_wmask", 64'(dmem_wmask), 64'hF0);
      chk("sw_wdata", dmem_wdata, 64'hDEADBEEF_00000000);
      chk("sw_wen", 64'(dmem_wen), 64'd1);
      @(negedge clk);
    end
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    chk("sw_wait_req", 64'(dmem_req_valid), 64'd0);
    dmem_resp_valid = 1'b1;
    dmem_rdata = 64'h0;
    @(negedge clk);
    dmem_resp_valid = 1'b0;
    chk("sw_wb_valid", 64'(wb_valid), 64'd1);
    chk("sw_wb_wen", 64'(wb_wen), 64'd0);
    chk("sw_busy", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("sw_wb_pulse", 64'(wb_valid), 64'd0);
    chk("sw_idle", 64'(in_ready), 64'd1);

    issue(MEM_SB, 64'h1003, 64'hAB, 5'd8, 1'b1);
    chk("sb_wmask", 64'(dmem_wmask), 64'h08);
    chk("sb_wdata", dmem_wdata, 64'h00000000_AB000000);
    chk("sb_addr", 64'(dmem_addr), 64'h1000);
    finish_txn(64'd0);
    chk("sb_wb_wen", 64'(wb_wen), 64'd0);
    @(negedge clk);

    issue(MEM_SH, 64'h1006, 64'h1122, 5'd8, 1'b1);
    chk("sh_wmask", 64'(dmem_wmask), 64'hC0);
    chk("sh_wdata", dmem_wdata, 64'h1122_0000_0000_0000);
    finish_txn(64'd0);
    @(negedge clk);

    issue(MEM_SD, 64'h1008, 64'h0102030405060708, 5'd8, 1'b1);
    chk("sd_wmask", 64'(dmem_wmask), 64'hFF);
    chk("sd_addr", 64'(dmem_addr), 64'h1008);
    chk("sd_wdata", dmem_wdata, 64'h0102030405060708);
    finish_txn(64'd0);
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      issue(lt_op[i], lt_addr[i], 64'd0, 5'd5, 1'b1);
      chk("ld_wmask", 64'(dmem_wmask), 64'h00);
      chk("ld_wen", 64'(dmem_wen), 64'd0);
      finish_txn(lt_rdata[i]);
      chk("ld_wb_valid", 64'(wb_valid), 64'd1);
      chk("ld_wb_data", wb_data, lt_exp[i]);
      chk("ld_wb_wen", 64'(wb_wen), 64'd1);
      chk("ld_wb_rd", 64'(wb_rd_addr), 64'd5);
      @(negedge clk);
    end

    issue(MEM_LW, 64'h4000, 64'd0, 5'd0, 1'b1);
    finish_txn(64'h11111111_22222222);
    chk("x0_wb_valid", 64'(wb_valid), 64'd1);
    chk("x0_wb_wen", 64'(wb_wen), 64'd0);
    @(negedge clk);

    issue(MEM_LD, 64'h5000, 64'd0, 5'd9, 1'b1);
    dmem_req_ready = 1'b1;
    dmem_resp_valid = 1'b1;
    dmem_rdata = 64'hBAD;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    dmem_resp_valid = 1'b0;
    chk("stall_no_capture", 64'(wb_valid), 64'd0);
    @(negedge clk);
    chk("stall_still_wait", 64'(wb_valid), 64'd0);
    dmem_resp_valid = 1'b1;
    dmem_rdata = 64'h01234567_89ABCDEF;
    @(negedge clk);
    dmem_resp_valid = 1'b0;
    chk("stall_wb_valid", 64'(wb_valid), 64'd1);
    chk("stall_wb_data", wb_data, 64'h01234567_89ABCDEF);
    @(negedge clk);

    issue(MEM_LH, 64'h2001, 64'd0, 5'd6, 1'b1);
    chk("mis_lh_valid", 64'(wb_valid), 64'd1);
    chk("mis_lh_flag", 64'(misalign), 64'd1);
    chk("mis_lh_wen", 64'(wb_wen), 64'd0);
    chk("mis_lh_req", 64'(dmem_req_valid), 64'd0);
    @(negedge clk);
    chk("mis_lh_req2", 64'(dmem_req_valid), 64'd0);
    chk("mis_lh_ready", 64'(in_ready), 64'd1);
    chk("mis_lh_clear", 64'(misalign), 64'd0);
    issue(MEM_LW, 64'h4002, 64'd0, 5'd6, 1'b1);
    chk("mis_lw_flag", 64'(misalign), 64'd1);
    chk("mis_lw_req", 64'(dmem_req_valid), 64'd0);
    issue(MEM_SD, 64'h1004, 64'd0, 5'd6, 1'b1);
    chk("mis_sd_flag", 64'(misalign), 64'd1);
    chk("mis_sd_req", 64'(dmem_req_valid), 64'd0);
    issue(MEM_LW, 64'h4004, 64'd0, 5'd6, 1'b1);
    chk("al_lw_flag", 64'(misalign), 64'd0);
    chk("al_lw_req", 64'(dmem_req_valid), 64'd1);
    finish_txn(64'd0);
    @(negedge clk);

    issue(MEM_LD, 64'h3000, 64'd0, 5'd4, 1'b1);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    chk("rstx_in_wait", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstx_in_ready", 64'(in_ready), 64'd1);
    chk("rstx_req", 64'(dmem_req_valid), 64'd0);
    chk("rstx_wb_valid", 64'(wb_valid), 64'd0);
    chk("rstx_addr", 64'(dmem_addr), 64'd0);
    rst = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_rdata = 64'h5555;
    @(negedge clk);
    dmem_resp_valid = 1'b0;
    chk("rstx_resp_ignored", 64'(wb_valid), 64'd0);
    chk("rstx_ready_after", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("rstx_no_pulse", 64'(wb_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter XLEN, default 64: datapath width.
REQ-002 Parameter ADDR_W, default 32: data-memory byte-address width.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  async active-high reset
REQ-004 Execute-side ports:
- in_valid  in  1  execute result presented
- in_ready  out  1  stage can accept
- alu_result  in  XLEN  execute result, or effective address for memory ops
- store_data  in  XLEN  rs2 value
- mem_op  in  4  NONE, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD
- rd_addr  in  5  destination register
- rd_wen  in  1  destination write enable
REQ-005 Data-memory ports:
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  request accepted
- dmem_addr  out  ADDR_W  8-byte-aligned address
- dmem_wen  out  1  1 = store
- dmem_wdata  out  XLEN  lane-shifted store data
- dmem_wmask  out  8  byte enables
- dmem_resp_valid  in  1  response valid
- dmem_rdata  in  XLEN  aligned read doubleword
REQ-006 Writeback-side ports:
- wb_valid  out  1  one-cycle writeback pulse
- wb_rd_addr  out  5  destination register
- wb_wen  out  1  register write enable
- wb_data  out  XLEN  writeback data
- misalign  out  1  misaligned access flag, qualified by wb_valid

Function
REQ-007 FSM states SHALL be IDLE, REQ, WAIT, RESP; in_ready SHALL equal (state==IDLE).
REQ-008 Acceptance: in_valid && in_ready SHALL latch all execute-side inputs into internal registers.
REQ-009 IDLE, mem_op==NONE: next cycle wb_valid=1, wb_data=alu_result, wb_wen=rd_wen; state stays IDLE (latency 1).
REQ-010 IDLE, misaligned op (H at odd address, W at addr[1:0]!=0, D at addr[2:0]!=0): next cycle wb_valid=1, misalign=1, wb_wen=0; no dmem request issued.
REQ-011 IDLE, aligned memory op: state goes to REQ.
REQ-012 REQ: dmem_req_valid=1; address, wen, wdata and mask SHALL stay stable until dmem_req_ready; on ready, go to WAIT.
REQ-013 WAIT: on dmem_resp_valid, go to RESP and capture dmem_rdata.
REQ-014 RESP: wb_valid=1 for exactly one cycle, then return to IDLE; a store SHALL give wb_wen=0.
REQ-015 Addressing: dmem_addr SHALL be the address with bits [2:0] cleared.
REQ-016 Store mask: SB 1<<off, SH 3<<off, SW 0x0F<<off, SD 0xFF, where off = address[2:0].
REQ-017 Store data: dmem_wdata SHALL be store_data shifted left by off*8.
REQ-018 Load data: rdata SHALL be shifted right by off*8, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU) to XLEN; LD SHALL pass all 64 bits.
REQ-019 Loads to x0: wb_wen SHALL be forced 0 when wb_rd_addr==0.
REQ-020 Stall: a response arriving in the same cycle as request acceptance SHALL NOT be captured; responses count only in WAIT.
REQ-021 Outputs: all wb_* outputs SHALL be registered; dmem_* outputs SHALL derive from state and latched registers only.

Reset
REQ-022 Asserting rst at any time, including mid-transaction, SHALL force state IDLE and set wb_valid=0, wb_wen=0, misalign=0, dmem_req_valid=0, and wb_data, wb_rd_addr, dmem_addr, dmem_wdata, dmem_wmask all to zero.
REQ-023 After reset, in_ready=1; an outstanding memory response arriving after reset SHALL be ignored.

Structure
REQ-024 The mem_op encodings and the FSM state encodings SHALL live in the shared defines package, next to the ALU op codes.
REQ-025 Load alignment and extension SHALL be one combinational sub-module, load_align (inputs: rdata, offset, mem_op; output: aligned XLEN value).

Verification
REQ-026 mem_op=NONE, alu_result=0x1234 -> one cycle later wb_valid=1, wb_data=0x1234, no dmem request.
REQ-027 SW, addr 0x1004, store_data=0xDEADBEEF, ready held low 3 cycles -> dmem_addr=0x1000, wmask=0xF0, wdata=0xDEADBEEF_00000000, stable for all 3 cycles; wb_wen=0.
REQ-028 LB, addr 0x2003, rdata=0x00000000_80000000 -> wb_data=0xFFFFFFFF_FFFFFF80; the same access as LBU -> 0x80.
REQ-029 LH, addr 0x2001 -> misalign=1, wb_wen=0, no dmem_req_valid asserted.
REQ-030 LD issued, rst asserted in WAIT, then dmem_resp_valid -> state IDLE, no wb_valid pulse, in_ready=1.
REQ-031 Load with rd_addr=0 -> wb_valid=1 and wb_wen=0.
